bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD (double-dabble) block. It takes a packed multi-digit BCD word and produces the equivalent unsigned binary value using reverse double dabble: one right-shift-and-correct step per clock. It sits behind keypad and UART digit-entry logic, where decimal operands are turned back into binary for counters and comparators, and it uses a valid/ready handshake on both sides.

---
 rtl/bcd_to_bin_seq.sv | 138 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// One right-shift-and-correct step per clock, valid/ready on both sides.
// A word with any digit above 9 still takes the full conversion time,
// then reports err=1 with a zero result.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIGITS*4-1:0]   num_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      num_out,
  output logic                  err
);

  localparam int BCD_W = DIGITS * 4;
  localparam int W_W   = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [W_W-1:0]   work;
  logic [W_W-1:0]   shifted;
  logic [W_W-1:0]   corrected;
  logic [CNT_W-1:0] cnt;
  logic             err_r;
  logic             digit_err;
  logic             last_step;

  assign in_ready  = (state == IDLE) & sys_rst_n;
  assign last_step = (state == CONV) && (cnt == LAST_CNT);

  // Flag any input digit that is not a legal BCD value (above 9).
  always_comb begin
    digit_err = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (num_in[4*d +: 4] > 4'd9) begin
        digit_err = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift right, then fix up BCD fields >= 8.
  always_comb begin
    shifted   = work >> 1;
    corrected = shifted;
    for (int d = 0; d < DIGITS; d++) begin
      if (shifted[BIN_W + 4*d +: 4] >= 4'd8) begin
        corrected[BIN_W + 4*d +: 4] = shifted[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept in IDLE, step through CONV, hold result in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = CONV;
        end
      end
      CONV: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load the word, iterate the working register, publish the result.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      work      <= '0;
      cnt       <= '0;
      err_r     <= 1'b0;
      out_valid <= 1'b0;
      num_out   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= {num_in, {BIN_W{1'b0}}};
            cnt   <= '0;
            err_r <= digit_err;
          end
        end
        CONV: begin
          work <= corrected;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            out_valid <= 1'b1;
            num_out   <= err_r ? '0 : corrected[BIN_W-1:0];
            err       <= err_r;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: driver pushes expected results,
// a monitor pops and compares whenever a result is handed off.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                sys_clk;
  logic                sys_rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [DIGITS*4-1:0] num_in;
  logic                out_valid;
  logic                out_ready;
  logic [BIN_W-1:0]    num_out;
  logic                err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = -1;
  bit gap_check = 0;
  int ready_mode = 0;

  logic [BIN_W:0] exp_q[$];
  int             acc_q[$];

  logic             prev_ov;
  logic             prev_stall;
  logic [BIN_W-1:0] prev_num;
  logic             prev_err;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num_in   (num_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .num_out  (num_out),
    .err      (err)
  );

  // Free-running clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Count rising edges so latencies can be measured.
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
  end

  // Drive out_ready: forced high, forced low, or random.
  always @(posedge sys_clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: decimal value of the digits, or error with zero result.
  function automatic logic [BIN_W:0] ref_model(input logic [DIGITS*4-1:0] bcd);
    int val;
    bit bad;
    int dig;
    val = 0;
    bad = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = int'((bcd >> (4 * i)) & 15);
      if (dig > 9) bad = 1;
      val = val * 10 + dig;
    end
    if (bad) return {1'b1, {BIN_W{1'b0}}};
    return {1'b0, BIN_W'(val)};
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at cycle %0d", name, cyc);
  endtask

  // Present one word and wait (bounded) for it to be accepted.
  task automatic apply_stimulus(input logic [DIGITS*4-1:0] bcd);
    int waited;
    bit got;
    waited = 0;
    got = 0;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1;
    num_in   = bcd;
    while (!got && waited < 200) begin
      @(negedge sys_clk);
      if (in_ready) got = 1;
      else waited++;
    end
    if (got) begin
      exp_q.push_back(ref_model(bcd));
      if (gap_check && last_acc >= 0) begin
        check_output("accept_period", cyc + 1 - last_acc, BIN_W + 2);
      end
      last_acc = cyc + 1;
    end else begin
      report_fail("accept_timeout");
    end
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) report_fail("drain_timeout");
  endtask

  // Monitor: latency on each new result, hold stability while stalled,
  // and scoreboard compare on each handshake.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_ov    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          report_fail("unexpected_output");
        end else begin
          check_output("latency", cyc - acc_q.pop_front(), BIN_W);
        end
      end
      if (prev_stall) begin
        check_output("hold_valid", int'(out_valid), 1);
        check_output("hold_num", int'(num_out), int'(prev_num));
        check_output("hold_err", int'(err), int'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_handshake");
        end else begin
          logic [BIN_W:0] e;
          e = exp_q.pop_front();
          check_output("num_out", int'(num_out), int'(e[BIN_W-1:0]));
          check_output("err", int'(err), int'(e[BIN_W]));
        end
      end
      prev_ov    = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_num   = num_out;
      prev_err   = err;
    end
  end

  initial begin
    logic [3:0] d0, d1, d2;
    int n;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    num_in    = '0;
    out_ready = 1'b1;

    // Reset held three cycles.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_output("in_ready_in_reset", int'(in_ready), 0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_num_out", int'(num_out), 0);
    check_output("rst_err", int'(err), 0);
    check_output("rst_in_ready", int'(in_ready), 1);

    // Single word and boundary values.
    apply_stimulus(12'h255);
    wait_drain();
    apply_stimulus(12'h000);
    apply_stimulus(12'h999);
    apply_stimulus(12'h1A3);
    wait_drain();

    // Back-to-back sweep of every legal three-digit value.
    gap_check = 1;
    last_acc  = -1;
    for (int v = 0; v < 1000; v++) begin
      d2 = 4'(v / 100);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
      apply_stimulus({d2, d1, d0});
    end
    gap_check = 0;
    wait_drain();

    // Stalled output with ignored in_valid pulses during CONV and DONE.
    @(negedge sys_clk);
    ready_mode = 1;
    apply_stimulus(12'h042);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1;
    num_in   = 12'h777;
    repeat (2) @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (!out_valid) report_fail("stall_out_valid_timeout");
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1;
    num_in   = 12'h777;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    ready_mode = 0;
    wait_drain();
    repeat (20) @(negedge sys_clk);

    // Reset mid-conversion aborts the word.
    apply_stimulus(12'h888);
    repeat (4) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_output("abort_out_valid", int'(out_valid), 0);
    check_output("abort_in_ready", int'(in_ready), 1);
    repeat (20) @(negedge sys_clk);
    apply_stimulus(12'h007);
    wait_drain();

    // Randomized words, legal and illegal, with random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus(12'($urandom));
      end else begin
        d2 = 4'($urandom_range(0, 9));
        d1 = 4'($urandom_range(0, 9));
        d0 = 4'($urandom_range(0, 9));
        apply_stimulus({d2, d1, d0});
      end
    end
    wait_drain();
    ready_mode = 0;
    repeat (5) @(negedge sys_clk);
    if (acc_q.size() != 0) report_fail("missing_output");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
